dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_align_chk.sv | 21 ++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: memop encodings, FSM states and port ids.
package dmem_arb_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic port_id_t;
    localparam port_id_t PORT_M0 = 1'b0;
    localparam port_id_t PORT_M1 = 1'b1;

    function automatic logic [1:0] port_onehot(input port_id_t id);
        return (id == PORT_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational misalignment check for halfword and word accesses.
module dmem_align_chk
    import dmem_arb_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] memop,
    output logic       misaligned
);

    // NOTE: default assignment first so no path through the case leaves
    // the output unassigned and infers a latch.
    always_comb begin
        misaligned = 1'b0;
        case (memop)
            MEMOP_LH, MEMOP_LHU: misaligned = addr[0];
            MEMOP_LW:            misaligned = (addr != 2'b00);
            default:             misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU on m0, debug/DMA on m1) with a 3-state FSM.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise m0 wins.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [2:0]    m0_memop,
    input  logic          m0_we,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [2:0]    m1_memop,
    input  logic          m1_we,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    output logic [2:0]    mem_memop,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dataout
);

    state_t        state;
    port_id_t      win_id;
    port_id_t      id_q;
    logic          any_req;
    logic          mis;
    logic          mis_q;
    logic          we_q;
    logic          mem_we_q;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [2:0]    sel_memop;
    logic          sel_we;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_datain_q;
    logic [2:0]    mem_memop_q;
    logic [1:0]    gnt_q;
    logic [1:0]    err_q;
    logic [1:0]    rvalid_q;
    logic [DW-1:0] rdata_q [2];
    logic [DW-1:0] resp_data;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    port_id_t      rr_q;
`endif

    assign any_req = m0_req | m1_req;

    always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) win_id = rr_q;
        else                  win_id = m0_req ? PORT_M0 : PORT_M1;
`else
        win_id = m0_req ? PORT_M0 : PORT_M1;
`endif
        sel_addr  = (win_id == PORT_M1) ? m1_addr  : m0_addr;
        sel_wdata = (win_id == PORT_M1) ? m1_wdata : m0_wdata;
        sel_memop = (win_id == PORT_M1) ? m1_memop : m0_memop;
        sel_we    = (win_id == PORT_M1) ? m1_we    : m0_we;
    end

    dmem_align_chk u_align_chk (
        .addr       (sel_addr[1:0]),
        .memop      (sel_memop),
        .misaligned (mis)
    );

    // A misaligned read completes normally but returns zero.
    assign resp_data = mis_q ? '0 : mem_dataout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            id_q         <= PORT_M0;
            we_q         <= 1'b0;
            mis_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
            mem_memop_q  <= '0;
            mem_we_q     <= 1'b0;
            gnt_q        <= '0;
            err_q        <= '0;
            rvalid_q     <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_q         <= PORT_M0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        id_q         <= win_id;
                        we_q         <= sel_we;
                        mis_q        <= mis;
                        mem_addr_q   <= sel_addr;
                        mem_datain_q <= sel_wdata;
                        mem_memop_q  <= sel_memop;
                        mem_we_q     <= sel_we & ~mis;
                        gnt_q        <= port_onehot(win_id);
                        err_q        <= mis ? port_onehot(win_id) : 2'b00;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        rr_q         <= ~win_id;
`endif
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_q    <= '0;
                    err_q    <= '0;
                    mem_we_q <= 1'b0;
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        rvalid_q <= port_onehot(id_q);
                        state    <= RESP;
                    end
                end
                RESP: begin
                    rvalid_q      <= '0;
                    rdata_q[id_q] <= resp_data;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are masked by rst so an in-flight access is dropped in the reset cycle itself.
    assign m0_gnt    = gnt_q[0] & ~rst;
    assign m1_gnt    = gnt_q[1] & ~rst;
    assign m0_err    = err_q[0] & ~rst;
    assign m1_err    = err_q[1] & ~rst;
    assign m0_rvalid = rvalid_q[0] & ~rst;
    assign m1_rvalid = rvalid_q[1] & ~rst;
    assign m0_rdata  = m0_rvalid ? resp_data : rdata_q[0];
    assign m1_rdata  = m1_rvalid ? resp_data : rdata_q[1];

    assign mem_addr   = mem_addr_q;
    assign mem_datain = mem_datain_q;
    assign mem_memop  = mem_memop_q;
    assign mem_we     = mem_we_q & ~rst;

endmodule
